// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, forms PC+4 and the jump target, selects the next PC from
// the sequential / branch / jump sources returned by decode, and carries
// the IF/ID pipeline register (InstrD, PCPlus4D, ValidD) into decode.
// PCF and all IF/ID outputs come straight from flops, so there is no
// combinational path from InstrF or the redirect inputs to any output.
module fetch_stage #(
    parameter int unsigned      PC_width     = 32,
    parameter int unsigned      Instr_width  = 32,
    parameter int unsigned      PCSrcD_width = 2,
    parameter logic [PC_width-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [Instr_width-1:0]  InstrF,
    input  logic [PCSrcD_width-1:0] PCSrcD,
    input  logic [PC_width-1:0]     PCBranchD,
    input  logic [25:0]             JumpInstrD,
    input  logic                    StallF,
    input  logic                    StallD,
    input  logic                    FlushD,
    output logic [PC_width-1:0]     PCF,
    output logic [Instr_width-1:0]  InstrD,
    output logic [PC_width-1:0]     PCPlus4D,
    output logic                    ValidD
);

    // PCSrcD bit positions: {jump, taken branch}
    localparam int unsigned SEL_JUMP   = 1;
    localparam int unsigned SEL_BRANCH = 0;

    // ---- stage p0: fetch (PC register, PC+4, next-PC selection) ----
    logic [PC_width-1:0] pc_plus4_p0;
    logic [PC_width-1:0] jump_target_p0;
    logic [PC_width-1:0] pc_next_p0;

    // PC+4 wraps modulo 2^PC_width; the carry out is intentionally dropped.
    assign pc_plus4_p0 = PCF + PC_width'(4);

    // Jump target keeps the top region bits of the jump's own PC+4 (in decode).
    assign jump_target_p0 = {PCPlus4D[PC_width-1:28], JumpInstrD, 2'b00};

    // Next-PC mux: jump outranks branch, sequential is the default.
    always_comb begin
        pc_next_p0 = pc_plus4_p0;
        if (PCSrcD[SEL_JUMP]) begin
            pc_next_p0 = jump_target_p0;
        end else if (PCSrcD[SEL_BRANCH]) begin
            pc_next_p0 = PCBranchD;
        end
    end

    // PC register: a fetch stall freezes the PC even when a redirect is pending.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= pc_next_p0;
        end
    end

    // ---- stage p1: IF/ID register feeding decode ----
    // IF/ID update: stall holds (decode's branch outcome is not yet valid, so
    // it must beat flush), flush inserts a nop bubble, otherwise capture fetch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            InstrD   <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (FlushD) begin
            InstrD   <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else begin
            InstrD   <= InstrF;
            PCPlus4D <= pc_plus4_p0;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction memory is modelled as a pure
// function of PCF, and every expectation is written out per test step.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_f;
    logic [1:0]  pc_src;
    logic [31:0] pc_branch;
    logic [25:0] jump_instr;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] pcf;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int checks;
    int failures;

    fetch_stage dut (
        .CLK        (clk),
        .RST        (rst),
        .InstrF     (instr_f),
        .PCSrcD     (pc_src),
        .PCBranchD  (pc_branch),
        .JumpInstrD (jump_instr),
        .StallF     (stall_f),
        .StallD     (stall_d),
        .FlushD     (flush_d),
        .PCF        (pcf),
        .InstrD     (instr_d),
        .PCPlus4D   (pc_plus4_d),
        .ValidD     (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a recognisable word per address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign instr_f = word(pcf);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        pc_src     = 2'b00;
        pc_branch  = 32'h0;
        jump_instr = 26'h0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
    endtask

    // Redirect via a taken branch (with the accompanying flush) for one edge.
    task automatic branch_to(input logic [31:0] tgt);
        pc_src    = 2'b01;
        pc_branch = tgt;
        flush_d   = 1'b1;
        tick();
        idle_ctrl();
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins,
                              input logic [31:0] p4, input logic v);
        check({tag, ".instr"}, instr_d, ins);
        check({tag, ".pc4"},   pc_plus4_d, p4);
        check({tag, ".valid"}, {31'h0, valid_d}, {31'h0, v});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_ctrl();

        // Reset state before any clock edge.
        #2;
        check("rst.pcf", pcf, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);

        // Edges while reset is held must not move anything.
        tick();
        tick();
        check("rst_hold.pcf", pcf, 32'h0);
        check("rst_hold.valid", {31'h0, valid_d}, 32'h0);
        rst = 1'b0;

        // Free run: PCF 4, 8, 12, IF/ID trails by one cycle.
        tick();
        check("run1.pcf", pcf, 32'h4);
        check_ifid("run1", word(32'h0), 32'h4, 1'b1);
        tick();
        check("run2.pcf", pcf, 32'h8);
        check_ifid("run2", word(32'h4), 32'h8, 1'b1);
        tick();
        check("run3.pcf", pcf, 32'hC);
        check_ifid("run3", word(32'h8), 32'hC, 1'b1);
        tick();
        check("run4.pcf", pcf, 32'h10);

        // Taken branch at 0x10 to 0x40, wrong-path fetch flushed.
        branch_to(32'h40);
        check("br.pcf", pcf, 32'h40);
        check_ifid("br.bubble", 32'h0, 32'h0, 1'b0);
        tick();
        check("br2.pcf", pcf, 32'h44);
        check_ifid("br2", word(32'h40), 32'h44, 1'b1);

        // Load-use stall for two cycles at PCF=0x20.
        branch_to(32'h1C);
        tick();
        check("pre_stall.pcf", pcf, 32'h20);
        stall_f = 1'b1;
        stall_d = 1'b1;
        tick();
        check("stall1.pcf", pcf, 32'h20);
        check_ifid("stall1", word(32'h1C), 32'h20, 1'b1);
        tick();
        check("stall2.pcf", pcf, 32'h20);
        check_ifid("stall2", word(32'h1C), 32'h20, 1'b1);
        idle_ctrl();
        tick();
        check("unstall.pcf", pcf, 32'h24);
        check_ifid("unstall", word(32'h20), 32'h24, 1'b1);

        // Stall beats flush and redirect.
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        flush_d   = 1'b1;
        pc_src    = 2'b01;
        pc_branch = 32'h80;
        tick();
        check("stflush.pcf", pcf, 32'h24);
        check_ifid("stflush", word(32'h20), 32'h24, 1'b1);
        idle_ctrl();

        // Jump priority: PCPlus4D = 0x1000_0008, target 0x1000_0040 not 0x80.
        branch_to(32'h1000_0004);
        tick();
        check("pre_jmp.pcf", pcf, 32'h1000_0008);
        check("pre_jmp.pc4", pc_plus4_d, 32'h1000_0008);
        pc_src     = 2'b11;
        pc_branch  = 32'h80;
        jump_instr = 26'h000_0010;
        flush_d    = 1'b1;
        tick();
        check("jmp11.pcf", pcf, 32'h1000_0040);
        check("jmp11.valid", {31'h0, valid_d}, 32'h0);
        idle_ctrl();

        // Plain jump (PCSrcD=10) from PCPlus4D=0x1000_0044.
        tick();
        check("pre_j10.pc4", pc_plus4_d, 32'h1000_0044);
        pc_src     = 2'b10;
        jump_instr = 26'h000_0020;
        flush_d    = 1'b1;
        tick();
        check("jmp10.pcf", pcf, 32'h1000_0080);
        idle_ctrl();

        // Asynchronous reset between edges at PCF=0x30.
        branch_to(32'h2C);
        tick();
        check("pre_arst.pcf", pcf, 32'h30);
        check("pre_arst.valid", {31'h0, valid_d}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.pcf", pcf, 32'h0);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        tick();
        check("arst_hold.pcf", pcf, 32'h0);
        rst = 1'b0;
        tick();
        check("arst_rel.pcf", pcf, 32'h4);
        check_ifid("arst_rel", word(32'h0), 32'h4, 1'b1);

        // PC wrap from 0xFFFF_FFFC.
        branch_to(32'hFFFF_FFFC);
        check("wrap0.pcf", pcf, 32'hFFFF_FFFC);
        tick();
        check("wrap.pcf", pcf, 32'h0);
        check_ifid("wrap", word(32'hFFFF_FFFC), 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
